// File: rtl/cam_arbiter_if.sv
// Requester and CAM-side signal bundle for cam_arbiter.
// The slave modport is the arbiter's view; master is the client/CAM-side view.
interface cam_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [IDX_W*NUM_REQ-1:0]  req_index;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [IDX_W-1:0]          rsp_index;
  logic                      rsp_hit;
  logic                      cam_read;
  logic [IDX_W-1:0]          cam_read_index;
  logic                      cam_write;
  logic [IDX_W-1:0]          cam_write_index;
  logic [DATA_W-1:0]         cam_write_data;
  logic                      cam_search;
  logic [DATA_W-1:0]         cam_search_data;
  logic [DATA_W-1:0]         cam_read_value;
  logic                      cam_search_valid;
  logic [IDX_W-1:0]          cam_search_index;

  modport slave (
    input  req_valid, req_op, req_index, req_data,
    input  cam_read_value, cam_search_valid, cam_search_index,
    output req_ready, rsp_valid, rsp_data, rsp_index, rsp_hit,
    output cam_read, cam_read_index, cam_write, cam_write_index, cam_write_data,
    output cam_search, cam_search_data
  );

  modport master (
    output req_valid, req_op, req_index, req_data,
    output cam_read_value, cam_search_valid, cam_search_index,
    input  req_ready, rsp_valid, rsp_data, rsp_index, rsp_hit,
    input  cam_read, cam_read_index, cam_write, cam_write_index, cam_write_data,
    input  cam_search, cam_search_data
  );
endinterface

// File: rtl/cam_arbiter.sv
// Round-robin arbiter serialising read/write/search ops from NUM_REQ requesters onto one CAM.
// Optional CAM_ARB_PRIO_EN: requester 0 gets absolute priority, rr among the rest.
module cam_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CAM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  cam_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;
  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
`ifdef CAM_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [PTR_W-1:0]    r_rr_ptr, r_owner, w_gnt, w_kp;
  logic [1:0]          r_op, w_sel_op;
  logic [IDX_W-1:0]    r_index, w_sel_index, r_rsp_index;
  logic [DATA_W-1:0]   r_data, w_sel_data, r_rsp_data;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_hit, w_found, w_accept, w_cap, w_issue;
  int                  w_k;
  logic [1:0]          w_op_arr   [NUM_REQ];
  logic [IDX_W-1:0]    w_idx_arr  [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op_arr[g]   = bus.req_op[g*2 +: 2];
    assign w_idx_arr[g]  = bus.req_index[g*IDX_W +: IDX_W];
    assign w_data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // Scan cyclically starting just after the rr pointer; first valid requester wins.
  always_comb begin
    w_found     = 1'b0;
    w_gnt       = '0;
    w_sel_op    = '0;
    w_sel_index = '0;
    w_sel_data  = '0;
    w_k         = 0;
    w_kp        = '0;
    if (PRIO_EN && bus.req_valid[0]) begin
      w_found     = 1'b1;
      w_sel_op    = w_op_arr[0];
      w_sel_index = w_idx_arr[0];
      w_sel_data  = w_data_arr[0];
    end
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      w_k  = (int'(r_rr_ptr) + i) % int'(NUM_REQ);
      w_kp = PTR_W'(w_k);
      if (!w_found && (!PRIO_EN || w_kp != '0) && bus.req_valid[w_kp]) begin
        w_found     = 1'b1;
        w_gnt       = w_kp;
        w_sel_op    = w_op_arr[w_kp];
        w_sel_index = w_idx_arr[w_kp];
        w_sel_data  = w_data_arr[w_kp];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_cap     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_accept  = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (r_cnt == '0) begin
          w_cap     = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
      r_owner     <= '0;
      r_op        <= '0;
      r_index     <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_rsp_data  <= '0;
      r_rsp_index <= '0;
      r_rsp_hit   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op    <= w_sel_op;
        r_index <= w_sel_index;
        r_data  <= w_sel_data;
        r_owner <= w_gnt;
        if (!(PRIO_EN && w_gnt == '0)) r_rr_ptr <= w_gnt;
      end
      if (r_state == StIssue) begin
        r_cnt <= CNT_W'(CAM_LAT - 1);
      end else if (r_state == StWait && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_cap) begin
        r_rsp_data  <= (r_op == OP_READ) ? bus.cam_read_value : '0;
        r_rsp_hit   <= (r_op == OP_SEARCH) && bus.cam_search_valid;
        r_rsp_index <= (r_op == OP_SEARCH && bus.cam_search_valid) ? bus.cam_search_index : '0;
      end
    end
  end

  // Reset gates handshake and strobes in the same cycle so an aborted op leaves no trace.
  assign w_issue = (r_state == StIssue) && !reset;

  assign bus.req_ready = (r_state == StIdle && w_found && !reset) ?
                         (NUM_REQ'(1) << w_gnt) : '0;
  assign bus.rsp_valid = (r_state == StResp && !reset) ? (NUM_REQ'(1) << r_owner) : '0;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_index = r_rsp_index;
  assign bus.rsp_hit   = r_rsp_hit;

  assign bus.cam_read        = w_issue && (r_op == OP_READ);
  assign bus.cam_read_index  = bus.cam_read ? r_index : '0;
  assign bus.cam_write       = w_issue && (r_op == OP_WRITE);
  assign bus.cam_write_index = bus.cam_write ? r_index : '0;
  assign bus.cam_write_data  = bus.cam_write ? r_data : '0;
  assign bus.cam_search      = w_issue && (r_op == OP_SEARCH);
  assign bus.cam_search_data = bus.cam_search ? r_data : '0;

endmodule
